// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio sample types and helpers
package audio_pkg;

    localparam int AUDIO_DATA_W = 16;

    typedef struct packed {
        logic signed [AUDIO_DATA_W-1:0] left;
        logic signed [AUDIO_DATA_W-1:0] right;
    } sample_pair_t;

    // The most negative code has no positive twin, so it saturates to full scale.
    function automatic logic [AUDIO_DATA_W-2:0] sat_abs(input logic signed [AUDIO_DATA_W-1:0] x);
        logic [AUDIO_DATA_W-1:0] mag;
        mag = x[AUDIO_DATA_W-1] ? (~x + 1'b1) : x;
        return mag[AUDIO_DATA_W-1] ? {(AUDIO_DATA_W-1){1'b1}} : mag[AUDIO_DATA_W-2:0];
    endfunction

endpackage

// File: rtl/adc_sample_capture_if.sv
// rtl/adc_sample_capture_if.sv - sample-pair stream leaving the capture FIFO head
interface adc_sample_capture_if #(
    parameter int DATA_W = audio_pkg::AUDIO_DATA_W
);
    logic [2*DATA_W-1:0] tdata;
    logic                tvalid;
    logic                tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - show-ahead FIFO with same-edge push and pop
module sample_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign pop_ok  = pop && !empty;
    // A pop on the same edge frees the slot a full FIFO needs for the push.
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/adc_sample_capture.sv
// rtl/adc_sample_capture.sv - I2S ADC deserialiser with sample FIFO and windowed peak meter
module adc_sample_capture
    import audio_pkg::*;
#(
    parameter int DATA_W     = AUDIO_DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int PEAK_WIN   = 1024
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_adclrck,
    input  logic                 i_adcdat,
    input  logic                 i_enable,
    adc_sample_capture_if.master m_axis,
    output logic                 o_overflow,
    input  logic                 i_clr_ovf,
    output logic [DATA_W-2:0]    o_peak,
    output logic                 o_peak_valid
);
    localparam int CNT_W = 5;
    localparam int WIN_W = (PEAK_WIN > 1) ? $clog2(PEAK_WIN) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] DONE_BIT = CNT_W'(DATA_W);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(PEAK_WIN - 1);

    logic              lrck_q;
    logic              lrck_seen;
    logic              synced;
    logic              left_ok;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-2:0] shift_q;
    logic [DATA_W-1:0] left_word;
    logic [DATA_W-1:0] word_next;
    logic              transition;
    logic              falling;
    logic              capture;
    logic              word_done;

    logic                frame_q;
    logic [2*DATA_W-1:0] frame_data;

    logic [2*DATA_W-1:0] fifo_head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_pop_ok;

    logic [DATA_W-2:0] cur_max;
    logic [WIN_W-1:0]  win_cnt;
    logic [DATA_W-2:0] abs_l;
    logic [DATA_W-2:0] abs_r;
    logic [DATA_W-2:0] peak_next;

    assign transition = lrck_seen && (i_adclrck != lrck_q);
    assign falling    = transition && !i_adclrck;
    assign word_next  = {shift_q, i_adcdat};
    // bit_cnt parks at DATA_W once a word is complete, so trailing bits are ignored.
    assign capture    = synced && !transition && (bit_cnt < DONE_BIT);
    assign word_done  = capture && (bit_cnt == LAST_BIT);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lrck_q     <= 1'b0;
            lrck_seen  <= 1'b0;
            synced     <= 1'b0;
            left_ok    <= 1'b0;
            bit_cnt    <= '0;
            shift_q    <= '0;
            left_word  <= '0;
            frame_q    <= 1'b0;
            frame_data <= '0;
        end else begin
            lrck_q    <= i_adclrck;
            lrck_seen <= 1'b1;
            frame_q   <= 1'b0;
            if (transition) begin
                bit_cnt <= '0;
                if (falling) begin
                    synced  <= 1'b1;
                    left_ok <= 1'b0;
                end else if (bit_cnt != DONE_BIT) begin
                    left_ok <= 1'b0;
                end
            end else if (capture) begin
                shift_q <= word_next[DATA_W-2:0];
                bit_cnt <= bit_cnt + 1'b1;
                if (word_done && !lrck_q) begin
                    left_word <= word_next;
                    left_ok   <= 1'b1;
                end
                if (word_done && lrck_q && left_ok) begin
                    frame_q    <= i_enable;
                    frame_data <= {left_word, word_next};
                end
            end
        end
    end

    sample_fifo #(
        .WIDTH (2*DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .push      (frame_q),
        .push_data (frame_data),
        .pop       (m_axis.tready),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign m_axis.tdata  = fifo_head;
    assign m_axis.tvalid = !fifo_empty;
    assign fifo_pop_ok   = m_axis.tready && !fifo_empty;

    assign abs_l = sat_abs(frame_data[2*DATA_W-1:DATA_W]);
    assign abs_r = sat_abs(frame_data[DATA_W-1:0]);

    always_comb begin
        peak_next = cur_max;
        if (abs_l > peak_next) begin
            peak_next = abs_l;
        end
        if (abs_r > peak_next) begin
            peak_next = abs_r;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_overflow   <= 1'b0;
            o_peak       <= '0;
            o_peak_valid <= 1'b0;
            cur_max      <= '0;
            win_cnt      <= '0;
        end else begin
            if (frame_q && fifo_full && !fifo_pop_ok) begin
                o_overflow <= 1'b1;
            end else if (i_clr_ovf) begin
                o_overflow <= 1'b0;
            end

            o_peak_valid <= 1'b0;
            if (frame_q) begin
                if (win_cnt == WIN_LAST) begin
                    o_peak       <= peak_next;
                    o_peak_valid <= 1'b1;
                    cur_max      <= '0;
                    win_cnt      <= '0;
                end else begin
                    cur_max <= peak_next;
                    win_cnt <= win_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_adc_sample_capture.sv
// tb/tb_adc_sample_capture.sv - scoreboard bench for adc_sample_capture
module tb_adc_sample_capture;
    import audio_pkg::*;

    localparam int DW  = 16;
    localparam int WIN = 4;
    localparam int PAD = 3;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          lrck     = 1'b1;
    logic          dat      = 1'b0;
    logic          enable   = 1'b1;
    logic          clr_ovf  = 1'b0;
    logic          overflow;
    logic          peak_valid;
    logic [DW-2:0] peak;

    adc_sample_capture_if #(.DATA_W(DW)) axis ();

    adc_sample_capture #(
        .DATA_W     (DW),
        .FIFO_DEPTH (4),
        .PEAK_WIN   (WIN)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_adclrck    (lrck),
        .i_adcdat     (dat),
        .i_enable     (enable),
        .m_axis       (axis),
        .o_overflow   (overflow),
        .i_clr_ovf    (clr_ovf),
        .o_peak       (peak),
        .o_peak_valid (peak_valid)
    );

    always #5 clk = ~clk;

    int            n_cmp      = 0;
    int            n_bad      = 0;
    int            pop_count  = 0;
    int            peak_count = 0;
    sample_pair_t  exp_q [$];
    logic [DW-2:0] peak_q [$];
    int            win_n   = 0;
    int            win_max = 0;
    sample_pair_t  mon_pair;
    logic [DW-2:0] mon_peak;

    always begin
        @(negedge clk);
        #1;
        if (rst_n && axis.tvalid && axis.tready) begin
            n_cmp++;
            pop_count++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL pop_data: got %h want no pair", axis.tdata);
            end else begin
                mon_pair = exp_q.pop_front();
                if (axis.tdata !== mon_pair) begin
                    n_bad++;
                    $display("FAIL pop_data: got %h want %h", axis.tdata, mon_pair);
                end
            end
        end
        if (rst_n && peak_valid) begin
            n_cmp++;
            peak_count++;
            if (peak_q.size() == 0) begin
                n_bad++;
                $display("FAIL peak_pulse: got pulse with peak %h want no pulse", peak);
            end else begin
                mon_peak = peak_q.pop_front();
                if (peak !== mon_peak) begin
                    n_bad++;
                    $display("FAIL peak_value: got %h want %h", peak, mon_peak);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    function automatic int sat_abs_ref(input logic signed [DW-1:0] x);
        if (x == 16'sh8000) return 32767;
        return (x < 0) ? -int'(x) : int'(x);
    endfunction

    task automatic drive_bit(input logic lr, input logic d);
        @(negedge clk);
        lrck = lr;
        dat  = d;
    endtask

    task automatic send_half(input logic lr, input logic [DW-1:0] w, input int nbits, input int pad);
        drive_bit(lr, 1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(lr, w[DW-1-i]);
        for (int i = 0; i < pad; i++) drive_bit(lr, 1'b0);
    endtask

    task automatic model_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input bit pushed);
        int m;
        sample_pair_t p;
        if (pushed) begin
            p = {l, r};
            exp_q.push_back(p);
        end
        if (enable) begin
            m = win_max;
            if (sat_abs_ref(l) > m) m = sat_abs_ref(l);
            if (sat_abs_ref(r) > m) m = sat_abs_ref(r);
            if (win_n == WIN - 1) begin
                peak_q.push_back(15'(m));
                win_n   = 0;
                win_max = 0;
            end else begin
                win_max = m;
                win_n++;
            end
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input bit pushed);
        send_half(1'b0, l, DW, PAD);
        send_half(1'b1, r, DW, 0);
        model_frame(l, r, pushed);
        for (int i = 0; i < PAD; i++) drive_bit(1'b1, 1'b0);
    endtask

    task automatic drain(output bit ok);
        axis.tready = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            drive_bit(lrck, 1'b0);
            if (!axis.tvalid) begin
                ok = 1'b1;
                break;
            end
        end
        #2;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        lrck  = 1'b1;
        exp_q.delete();
        peak_q.delete();
        win_n   = 0;
        win_max = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) drive_bit(1'b1, 1'b0);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        n_cmp += 5;
        if (axis.tvalid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", axis.tvalid); end
        if (axis.tdata !== '0) begin n_bad++; $display("FAIL reset_data: got %h want 0", axis.tdata); end
        if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        if (peak !== '0) begin n_bad++; $display("FAIL reset_peak: got %h want 0", peak); end
        if (peak_valid !== 1'b0) begin n_bad++; $display("FAIL reset_peak_valid: got %b want 0", peak_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) drive_bit(1'b1, 1'b0);
    endtask

    task automatic test_single();
        axis.tready = 1'b1;
        send_half(1'b0, 16'h1234, DW, PAD);
        send_half(1'b1, 16'hABCD, DW, 0);
        model_frame(16'h1234, 16'hABCD, 1'b1);
        drive_bit(1'b1, 1'b0);
        #1;
        n_cmp++;
        if (axis.tvalid !== 1'b0) begin n_bad++; $display("FAIL single_lsb_edge_valid: got %b want 0", axis.tvalid); end
        drive_bit(1'b1, 1'b0);
        #1;
        n_cmp += 2;
        if (axis.tvalid !== 1'b1) begin n_bad++; $display("FAIL single_push_valid: got %b want 1", axis.tvalid); end
        if (axis.tdata !== 32'h1234ABCD) begin n_bad++; $display("FAIL single_data: got %h want 1234abcd", axis.tdata); end
        drive_bit(1'b1, 1'b0);
        #1;
        n_cmp++;
        if (axis.tvalid !== 1'b0) begin n_bad++; $display("FAIL single_after_pop_valid: got %b want 0", axis.tvalid); end
    endtask

    task automatic test_overflow();
        int pc;
        bit ok;
        axis.tready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send_frame(16'(i), 16'(16'h0100 + i), i <= 4);
            if (i == 4) begin
                n_cmp++;
                if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_after_fill: got %b want 0", overflow); end
            end
        end
        n_cmp++;
        if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %b want 1", overflow); end
        pc = pop_count;
        drain(ok);
        n_cmp += 3;
        if (!ok) begin n_bad++; $display("FAIL ovf_drain: got valid stuck high want empty"); end
        if (pop_count - pc != 4) begin n_bad++; $display("FAIL ovf_pop_count: got %0d want 4", pop_count - pc); end
        if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        @(negedge clk);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        #1;
        n_cmp++;
        if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    endtask

    task automatic test_full_pushpop();
        int pc;
        bit ok;
        axis.tready = 1'b0;
        for (int i = 0; i < 4; i++) send_frame(16'(16'hA000 + i), 16'(16'h0A00 + i), 1'b1);
        send_half(1'b0, 16'hA006, DW, PAD);
        send_half(1'b1, 16'h0A06, DW, 0);
        model_frame(16'hA006, 16'h0A06, 1'b1);
        drive_bit(1'b1, 1'b0);
        axis.tready = 1'b1;
        drive_bit(1'b1, 1'b0);
        axis.tready = 1'b0;
        #1;
        n_cmp += 3;
        if (overflow !== 1'b0) begin n_bad++; $display("FAIL pushpop_ovf: got %b want 0", overflow); end
        if (axis.tvalid !== 1'b1) begin n_bad++; $display("FAIL pushpop_valid: got %b want 1", axis.tvalid); end
        if (axis.tdata !== 32'hA0010A01) begin n_bad++; $display("FAIL pushpop_head: got %h want a0010a01", axis.tdata); end
        pc = pop_count;
        drain(ok);
        n_cmp += 2;
        if (!ok) begin n_bad++; $display("FAIL pushpop_drain: got valid stuck high want empty"); end
        if (pop_count - pc != 4) begin n_bad++; $display("FAIL pushpop_occupancy: got %0d want 4", pop_count - pc); end
    endtask

    task automatic test_truncate();
        int pc;
        axis.tready = 1'b1;
        pc = pop_count;
        send_half(1'b0, 16'hFFFF, 10, 0);
        send_half(1'b1, 16'h5555, DW, PAD);
        drive_bit(1'b1, 1'b0);
        #1;
        n_cmp += 2;
        if (pop_count != pc) begin n_bad++; $display("FAIL trunc_no_push: got %0d pops want 0", pop_count - pc); end
        if (axis.tvalid !== 1'b0) begin n_bad++; $display("FAIL trunc_valid: got %b want 0", axis.tvalid); end
        send_frame(16'h0F0F, 16'hF0F0, 1'b1);
        #2;
        n_cmp++;
        if (pop_count != pc + 1) begin n_bad++; $display("FAIL trunc_recover: got %0d pops want 1", pop_count - pc); end
    endtask

    task automatic test_enable();
        int pc;
        int kc;
        axis.tready = 1'b1;
        pc = pop_count;
        kc = peak_count;
        enable = 1'b0;
        for (int i = 0; i < WIN; i++) send_frame(16'h7000, 16'h7000, 1'b0);
        #2;
        n_cmp += 2;
        if (pop_count != pc) begin n_bad++; $display("FAIL enable_no_push: got %0d pops want 0", pop_count - pc); end
        if (peak_count != kc) begin n_bad++; $display("FAIL enable_no_peak: got %0d pulses want 0", peak_count - kc); end
        enable = 1'b1;
    endtask

    task automatic test_mid_reset();
        int pc;
        axis.tready = 1'b1;
        send_half(1'b0, 16'h1111, 6, 0);
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        peak_q.delete();
        win_n   = 0;
        win_max = 0;
        #1;
        n_cmp += 5;
        if (axis.tvalid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %b want 0", axis.tvalid); end
        if (axis.tdata !== '0) begin n_bad++; $display("FAIL midrst_data: got %h want 0", axis.tdata); end
        if (overflow !== 1'b0) begin n_bad++; $display("FAIL midrst_ovf: got %b want 0", overflow); end
        if (peak !== '0) begin n_bad++; $display("FAIL midrst_peak: got %h want 0", peak); end
        if (peak_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_peak_valid: got %b want 0", peak_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        pc = pop_count;
        for (int i = 7; i < DW; i++) drive_bit(1'b0, 1'b1);
        repeat (PAD) drive_bit(1'b0, 1'b0);
        send_half(1'b1, 16'h2222, DW, PAD);
        #2;
        n_cmp++;
        if (pop_count != pc) begin n_bad++; $display("FAIL midrst_discard: got %0d pops want 0", pop_count - pc); end
        send_frame(16'h3333, 16'h4444, 1'b1);
        #2;
        n_cmp++;
        if (pop_count != pc + 1) begin n_bad++; $display("FAIL midrst_first_frame: got %0d pops want 1", pop_count - pc); end
    endtask

    task automatic test_peak();
        int kc;
        axis.tready = 1'b1;
        apply_reset();
        kc = peak_count;
        send_frame(16'hFFFB, 16'h0003, 1'b1);
        send_frame(16'd100, 16'hFF38, 1'b1);
        send_frame(16'h8000, 16'h0000, 1'b1);
        send_frame(16'h0007, 16'h0007, 1'b1);
        #2;
        n_cmp += 2;
        if (peak !== 15'h7FFF) begin n_bad++; $display("FAIL peak_window1: got %h want 7fff", peak); end
        if (peak_count != kc + 1) begin n_bad++; $display("FAIL peak_pulse_count1: got %0d want 1", peak_count - kc); end
        for (int i = 0; i < WIN; i++) send_frame(16'h0000, 16'h0000, 1'b1);
        #2;
        n_cmp += 2;
        if (peak !== 15'h0000) begin n_bad++; $display("FAIL peak_window2: got %h want 0", peak); end
        if (peak_count != kc + 2) begin n_bad++; $display("FAIL peak_pulse_count2: got %0d want 2", peak_count - kc); end
    endtask

    initial begin
        axis.tready = 1'b0;
        test_reset();
        test_single();
        test_overflow();
        test_full_pushpop();
        test_truncate();
        test_enable();
        test_mid_reset();
        test_peak();
        repeat (4) drive_bit(1'b1, 1'b0);
        #2;
        n_cmp += 2;
        if (exp_q.size() != 0) begin n_bad++; $display("FAIL end_pairs_left: got %0d want 0", exp_q.size()); end
        if (peak_q.size() != 0) begin n_bad++; $display("FAIL end_peaks_left: got %0d want 0", peak_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
